// File: rtl/data_bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// A small register window feeds a TX FIFO that drives a baud-timed serialiser.
module data_bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int            PW    = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   DEPTH = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;

    logic          sel;
    logic [1:0]    reg_idx;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          ovf_clear;
    logic          baud_wr;
    logic [15:0]   baud_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic [15:0]   baud_div;

    logic [1:0]    state;
    logic [15:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    // Lanes and address bits the register map never looks at.
    logic unused_bits;
    assign unused_bits = ^{address[1:0], write_data[31:16], byte_enable[3:2]};

    assign sel       = (address[31:4] == BASE_ADDR[31:4]);
    assign reg_idx   = address[3:2];
    assign push_req  = sel && write_enable && (reg_idx == REG_TXDATA) && byte_enable[0];
    assign push      = push_req && !full;
    assign ovf_clear = sel && write_enable && (reg_idx == REG_STATUS) && byte_enable[0]
                       && write_data[3];
    assign baud_wr   = sel && write_enable && (reg_idx == REG_BAUD);

    assign full   = (count == DEPTH);
    assign empty  = (count == '0);
    assign busy   = (state != IDLE);
    assign pop    = (state == IDLE) && !empty;
    assign tx_irq = empty && !busy;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        baud_next = baud_div;
        if (byte_enable[0]) baud_next[7:0]  = write_data[7:0];
        if (byte_enable[1]) baud_next[15:8] = write_data[15:8];
        if (baud_next == 16'd0) baud_next = 16'd1;
    end

    always_comb begin
        read_data = 32'h0;
        if (sel && read_enable) begin
            case (reg_idx)
                REG_STATUS: begin
                    read_data[0]    = full;
                    read_data[1]    = empty;
                    read_data[2]    = busy;
                    read_data[3]    = overflow;
                    read_data[15:8] = 8'(count);
                end
                REG_BAUD: read_data[15:0] = baud_div;
                default:  read_data = 32'h0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full) overflow <= 1'b1;
            else if (ovf_clear)   overflow <= 1'b0;
            if (baud_wr) baud_div <= baud_next;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        cnt       <= baud_div - 16'd1;
                        state     <= START;
                    end
                end
                START: begin
                    if (cnt == 16'd0) begin
                        cnt     <= baud_div - 16'd1;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == 16'd0) begin
                        cnt <= baud_div - 16'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    if (cnt == 16'd0) state <= IDLE;
                    else              cnt   <= cnt - 16'd1;
                end
            endcase
        end
    end

    // Line level lags the state by one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uart_tx <= 1'b1;
        end else begin
            case (state)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= shift_reg[bit_idx];
                default: uart_tx <= 1'b1;
            endcase
        end
    end

endmodule
